// File: rtl/beam_scan.sv
// Delay-and-sum beam scanner: for one FFT bin, steers NBEAM beams across NMIC channels,
// streams per-beam power and reports the strongest beam with its direction of arrival.
module beam_scan #(
  parameter int unsigned NMIC      = 4,
  parameter int unsigned NBEAM     = 13,
  parameter int unsigned CW        = 14,
  parameter int unsigned BINW      = 10,
  parameter int          DOA_START = -90,
  parameter int          DOA_STEP  = 15,
  localparam int unsigned ACCW  = 2 * CW + 1 + $clog2(NMIC),
  localparam int unsigned PW    = 2 * ACCW + 1,
  localparam int unsigned BEAMW = (NBEAM > 1) ? $clog2(NBEAM) : 1,
  localparam int unsigned CAW   = (NBEAM * NMIC > 1) ? $clog2(NBEAM * NMIC) : 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [BINW-1:0]        maxbin,
  output logic [BINW-1:0]        rdaddr,
  input  logic [NMIC*2*CW-1:0]   spec_q,
  output logic [CAW-1:0]         coef_addr,
  input  logic [2*CW-1:0]        coef_q,
  output logic                   busy,
  output logic                   done,
  output logic                   pwr_valid,
  output logic [PW-1:0]          pwr,
  output logic [BEAMW-1:0]       pwr_beam,
  output logic [BEAMW-1:0]       best_beam,
  output logic [PW-1:0]          best_pwr,
  output logic signed [7:0]      doa
);

  localparam int unsigned MICW = (NMIC > 1) ? $clog2(NMIC) : 1;
  localparam int unsigned PRW  = 2 * CW + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CAPTURE,
    S_FETCH,
    S_MAC,
    S_COMPARE
  } state_t;

  state_t r_state;
  state_t w_next;

  logic                   r_cap_cnt;
  logic [MICW-1:0]        r_mic;
  logic [BEAMW-1:0]       r_beam;
  logic [CAW-1:0]         r_coef_addr;
  logic [BINW-1:0]        r_bin;
  logic [2*CW-1:0]        r_chan [NMIC];
  logic signed [ACCW-1:0] r_acc_re;
  logic signed [ACCW-1:0] r_acc_im;
  logic [PW-1:0]          r_run_max;
  logic [BEAMW-1:0]       r_run_best;
  logic                   r_busy;
  logic                   r_done;
  logic                   r_pwr_valid;
  logic [PW-1:0]          r_pwr;
  logic [BEAMW-1:0]       r_pwr_beam;
  logic [BEAMW-1:0]       r_best_beam;
  logic [PW-1:0]          r_best_pwr;
  logic signed [7:0]      r_doa;

  logic                     w_last_mic;
  logic                     w_last_beam;
  logic [2*CW-1:0]          w_x;
  logic signed [CW-1:0]     w_xr;
  logic signed [CW-1:0]     w_xi;
  logic signed [CW-1:0]     w_cr;
  logic signed [CW-1:0]     w_ci;
  logic signed [2*CW-1:0]   w_rr;
  logic signed [2*CW-1:0]   w_ii;
  logic signed [2*CW-1:0]   w_ri;
  logic signed [2*CW-1:0]   w_ir;
  logic signed [PRW-1:0]    w_prod_re;
  logic signed [PRW-1:0]    w_prod_im;
  logic signed [ACCW-1:0]   w_acc_re_nxt;
  logic signed [ACCW-1:0]   w_acc_im_nxt;
  logic signed [2*ACCW-1:0] w_sq_re;
  logic signed [2*ACCW-1:0] w_sq_im;
  logic [PW-1:0]            w_pwr;
  logic                     w_upd;
  logic [PW-1:0]            w_max_nxt;
  logic [BEAMW-1:0]         w_best_nxt;
  logic signed [7:0]        w_doa;

  assign w_last_mic  = (r_mic == MICW'(NMIC - 1));
  assign w_last_beam = (r_beam == BEAMW'(NBEAM - 1));

  // Complex MAC: steering coefficient times the captured sample of the current mic
  assign w_x       = r_chan[r_mic];
  assign w_xr      = w_x[2*CW-1:CW];
  assign w_xi      = w_x[CW-1:0];
  assign w_cr      = coef_q[2*CW-1:CW];
  assign w_ci      = coef_q[CW-1:0];
  assign w_rr      = w_cr * w_xr;
  assign w_ii      = w_ci * w_xi;
  assign w_ri      = w_cr * w_xi;
  assign w_ir      = w_ci * w_xr;
  assign w_prod_re = PRW'(w_rr) - PRW'(w_ii);
  assign w_prod_im = PRW'(w_ri) + PRW'(w_ir);

  assign w_acc_re_nxt = r_acc_re + ACCW'(w_prod_re);
  assign w_acc_im_nxt = r_acc_im + ACCW'(w_prod_im);

  // Power is formed from the post-MAC accumulators so it is ready in COMPARE
  assign w_sq_re = w_acc_re_nxt * w_acc_re_nxt;
  assign w_sq_im = w_acc_im_nxt * w_acc_im_nxt;
  assign w_pwr   = PW'($unsigned(w_sq_re)) + PW'($unsigned(w_sq_im));

  // Strict comparison keeps the lower beam index on ties
  assign w_upd      = (r_pwr > r_run_max);
  assign w_max_nxt  = w_upd ? r_pwr : r_run_max;
  assign w_best_nxt = w_upd ? r_beam : r_run_best;
  assign w_doa      = 8'(DOA_START + DOA_STEP * int'(w_best_nxt));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (start) w_next = S_CAPTURE;
      S_CAPTURE: if (r_cap_cnt) w_next = S_FETCH;
      S_FETCH:   w_next = S_MAC;
      S_MAC:     w_next = w_last_mic ? S_COMPARE : S_FETCH;
      S_COMPARE: w_next = w_last_beam ? S_IDLE : S_FETCH;
      default:   w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cap_cnt   <= 1'b0;
      r_mic       <= '0;
      r_beam      <= '0;
      r_coef_addr <= '0;
      r_bin       <= '0;
      for (int m = 0; m < int'(NMIC); m++) r_chan[m] <= '0;
      r_acc_re    <= '0;
      r_acc_im    <= '0;
      r_run_max   <= '0;
      r_run_best  <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_pwr_valid <= 1'b0;
      r_pwr       <= '0;
      r_pwr_beam  <= '0;
      r_best_beam <= '0;
      r_best_pwr  <= '0;
      r_doa       <= 8'(DOA_START);
    end else begin
      r_done      <= 1'b0;
      r_pwr_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_bin       <= maxbin;
            r_busy      <= 1'b1;
            r_cap_cnt   <= 1'b0;
            r_acc_re    <= '0;
            r_acc_im    <= '0;
            r_run_max   <= '0;
            r_run_best  <= '0;
            r_beam      <= '0;
            r_mic       <= '0;
            r_coef_addr <= '0;
          end
        end
        S_CAPTURE: begin
          r_cap_cnt <= 1'b1;
          if (r_cap_cnt) begin
            for (int m = 0; m < int'(NMIC); m++) r_chan[m] <= spec_q[m*2*CW +: 2*CW];
          end
        end
        S_MAC: begin
          r_acc_re <= w_acc_re_nxt;
          r_acc_im <= w_acc_im_nxt;
          if (w_last_mic) begin
            r_pwr       <= w_pwr;
            r_pwr_valid <= 1'b1;
            r_pwr_beam  <= r_beam;
          end else begin
            r_mic       <= r_mic + MICW'(1);
            r_coef_addr <= r_coef_addr + CAW'(1);
          end
        end
        S_COMPARE: begin
          r_run_max  <= w_max_nxt;
          r_run_best <= w_best_nxt;
          if (w_last_beam) begin
            r_busy      <= 1'b0;
            r_done      <= 1'b1;
            r_best_beam <= w_best_nxt;
            r_best_pwr  <= w_max_nxt;
            r_doa       <= w_doa;
          end else begin
            r_beam      <= r_beam + BEAMW'(1);
            r_mic       <= '0;
            r_coef_addr <= r_coef_addr + CAW'(1);
            r_acc_re    <= '0;
            r_acc_im    <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign rdaddr    = r_bin;
  assign coef_addr = r_coef_addr;
  assign busy      = r_busy;
  assign done      = r_done;
  assign pwr_valid = r_pwr_valid;
  assign pwr       = r_pwr;
  assign pwr_beam  = r_pwr_beam;
  assign best_beam = r_best_beam;
  assign best_pwr  = r_best_pwr;
  assign doa       = r_doa;

endmodule

// File: tb/tb_beam_scan.sv
// Randomized bench for beam_scan: registered RAM/ROM models, a per-beam complex-sum
// reference, latency, tie-break, ignored-start, back-to-back and mid-scan reset checks.
module tb_beam_scan;

  localparam int unsigned NMIC  = 4;
  localparam int unsigned NBEAM = 13;
  localparam int unsigned CW    = 14;
  localparam int unsigned BINW  = 10;
  localparam int unsigned ACCW  = 2 * CW + 1 + $clog2(NMIC);
  localparam int unsigned PW    = 2 * ACCW + 1;
  localparam int unsigned BEAMW = $clog2(NBEAM);
  localparam int unsigned CAW   = $clog2(NBEAM * NMIC);
  localparam int          LAT   = 3 + NBEAM * (2 * NMIC + 1);

  logic                   clk = 1'b0;
  logic                   reset;
  logic                   start;
  logic [BINW-1:0]        maxbin;
  logic [BINW-1:0]        rdaddr;
  logic [NMIC*2*CW-1:0]   spec_q;
  logic [CAW-1:0]         coef_addr;
  logic [2*CW-1:0]        coef_q;
  logic                   busy;
  logic                   done;
  logic                   pwr_valid;
  logic [PW-1:0]          pwr;
  logic [BEAMW-1:0]       pwr_beam;
  logic [BEAMW-1:0]       best_beam;
  logic [PW-1:0]          best_pwr;
  logic signed [7:0]      doa;

  beam_scan dut (
    .clk(clk), .reset(reset), .start(start), .maxbin(maxbin), .rdaddr(rdaddr),
    .spec_q(spec_q), .coef_addr(coef_addr), .coef_q(coef_q), .busy(busy), .done(done),
    .pwr_valid(pwr_valid), .pwr(pwr), .pwr_beam(pwr_beam), .best_beam(best_beam),
    .best_pwr(best_pwr), .doa(doa)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int acc_cyc = 0;

  int cre [NBEAM*NMIC];
  int cim [NBEAM*NMIC];
  int xr  [NMIC];
  int xi  [NMIC];
  logic [2*CW-1:0]      rom [NBEAM*NMIC];
  logic [NMIC*2*CW-1:0] ram_word;
  int                   cur_bin;

  longint exp_pwr [NBEAM];
  int     exp_best;
  longint exp_bestp;
  longint prev_best, prev_bestp, prev_doa;

  int     obs_beam [$];
  longint obs_pwr  [$];

  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) coef_q <= rom[coef_addr];
  always @(posedge clk) spec_q <= (rdaddr == BINW'(cur_bin)) ? ram_word : ~ram_word;

  always @(negedge clk) begin
    if (pwr_valid) begin
      obs_beam.push_back(int'(pwr_beam));
      obs_pwr.push_back(longint'(pwr));
    end
  end

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: per beam, complex sum over mics of coef * sample, power = |sum|^2
  task automatic compute_model();
    longint re, im, mx;
    mx = 0;
    exp_best = 0;
    for (int b = 0; b < int'(NBEAM); b++) begin
      re = 0;
      im = 0;
      for (int m = 0; m < int'(NMIC); m++) begin
        re += longint'(cre[b*NMIC+m]) * xr[m] - longint'(cim[b*NMIC+m]) * xi[m];
        im += longint'(cre[b*NMIC+m]) * xi[m] + longint'(cim[b*NMIC+m]) * xr[m];
      end
      exp_pwr[b] = re * re + im * im;
      if (exp_pwr[b] > mx) begin
        mx = exp_pwr[b];
        exp_best = b;
      end
    end
    exp_bestp = mx;
  endtask

  task automatic load_mem(input int bin);
    cur_bin = bin;
    for (int i = 0; i < int'(NBEAM * NMIC); i++) rom[i] = {CW'(cre[i]), CW'(cim[i])};
    for (int m = 0; m < int'(NMIC); m++) ram_word[m*2*CW +: 2*CW] = {CW'(xr[m]), CW'(xi[m])};
  endtask

  function automatic int rnd(input int lim);
    return int'($urandom_range(0, 2 * lim)) - lim;
  endfunction

  // mode 0: single beam 5 identity, 1: beams 3/7 tie, 2: full-range random, 3: small random
  task automatic set_data(input int mode);
    for (int i = 0; i < int'(NBEAM * NMIC); i++) begin
      cre[i] = 0;
      cim[i] = 0;
    end
    for (int m = 0; m < int'(NMIC); m++) begin
      xr[m] = (mode == 0) ? 100 : rnd(mode == 3 ? 50 : 8191);
      xi[m] = (mode == 0) ? 0   : rnd(mode == 3 ? 50 : 8191);
    end
    for (int m = 0; m < int'(NMIC); m++) begin
      case (mode)
        0: cre[5*NMIC+m] = 1;
        1: begin cre[3*NMIC+m] = 1; cim[7*NMIC+m] = 1; end
        default: ;
      endcase
    end
    if (mode >= 2) begin
      for (int i = 0; i < int'(NBEAM * NMIC); i++) begin
        cre[i] = rnd(mode == 3 ? 20 : 8191);
        cim[i] = rnd(mode == 3 ? 20 : 8191);
      end
    end
  endtask

  // chained: start is already high at the negedge of the previous done cycle
  task automatic run_scan(input int bin, input string tag, input bit chained, input int next_bin);
    int  k;
    int  nd;
    bit  got;
    compute_model();
    load_mem(bin);
    obs_beam.delete();
    obs_pwr.delete();
    if (!chained) @(negedge clk);
    maxbin = BINW'(bin);
    start  = 1'b1;
    @(posedge clk);
    #1;
    acc_cyc = cyc;
    start   = 1'b0;
    k   = 0;
    nd  = 0;
    got = 1'b0;
    while (k < 3 * LAT && !got) begin
      @(negedge clk);
      k++;
      start = (k == 10 || k == 60);
      if (start) maxbin = BINW'(bin ^ 21);
      if (k == 5) begin
        chk({tag, " rdaddr"}, longint'(rdaddr), longint'(bin));
        chk({tag, " busy"}, longint'(busy), 1);
      end
      if (k == 60) begin
        chk({tag, " held_best"}, longint'(best_beam), prev_best);
        chk({tag, " held_pwr"}, longint'(best_pwr), prev_bestp);
        chk({tag, " held_doa"}, longint'(doa), prev_doa);
      end
      if (done) begin
        nd++;
        got = 1'b1;
      end
    end
    start = 1'b0;
    chk({tag, " done_seen"}, longint'(nd), 1);
    chk({tag, " latency"}, longint'(k), longint'(LAT));
    chk({tag, " busy_at_done"}, longint'(busy), 0);
    chk({tag, " rdaddr_end"}, longint'(rdaddr), longint'(bin));
    chk({tag, " nvalid"}, longint'(obs_pwr.size()), longint'(NBEAM));
    for (int b = 0; b < int'(NBEAM) && b < obs_pwr.size(); b++) begin
      chk($sformatf("%s beam_idx%0d", tag, b), longint'(obs_beam[b]), longint'(b));
      chk($sformatf("%s pwr%0d", tag, b), obs_pwr[b], exp_pwr[b]);
    end
    chk({tag, " best_beam"}, longint'(best_beam), longint'(exp_best));
    chk({tag, " best_pwr"}, longint'(best_pwr), exp_bestp);
    chk({tag, " doa"}, longint'(doa), longint'(-90 + 15 * exp_best));
    prev_best  = exp_best;
    prev_bestp = exp_bestp;
    prev_doa   = -90 + 15 * exp_best;
    if (next_bin >= 0) begin
      maxbin = BINW'(next_bin);
      start  = 1'b1;
    end
  endtask

  initial begin
    int pv;
    int dn;
    reset  = 1'b1;
    start  = 1'b0;
    maxbin = '0;
    cur_bin = 0;
    ram_word = '0;
    for (int i = 0; i < int'(NBEAM * NMIC); i++) rom[i] = '0;
    prev_best  = 0;
    prev_bestp = 0;
    prev_doa   = -90;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst busy", longint'(busy), 0);
    chk("rst done", longint'(done), 0);
    chk("rst best_beam", longint'(best_beam), 0);
    chk("rst doa", longint'(doa), -90);
    chk("rst rdaddr", longint'(rdaddr), 0);
    chk("rst coef_addr", longint'(coef_addr), 0);
    chk("rst pwr_valid", longint'(pwr_valid), 0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    set_data(0);
    run_scan(37, "single", 1'b0, -1);
    chk("single pwr5", exp_pwr[5], 160000);

    set_data(1);
    run_scan(200, "tie", 1'b0, 513);
    chk("tie best", prev_best, 3);

    set_data(2);
    run_scan(513, "chain", 1'b1, -1);

    for (int t = 0; t < 6; t++) begin
      set_data(2 + (t % 2));
      run_scan(int'($urandom_range(0, 1023)), $sformatf("rand%0d", t), 1'b0, -1);
    end

    // Reset in cycle 50 of a scan aborts it and clears the results
    set_data(2);
    compute_model();
    load_mem(99);
    @(negedge clk);
    maxbin = BINW'(99);
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (49) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort busy", longint'(busy), 0);
    chk("abort best_beam", longint'(best_beam), 0);
    chk("abort best_pwr", longint'(best_pwr), 0);
    chk("abort doa", longint'(doa), -90);
    chk("abort rdaddr", longint'(rdaddr), 0);
    pv = 0;
    dn = 0;
    repeat (2 * LAT) begin
      @(negedge clk);
      if (pwr_valid) pv++;
      if (done) dn++;
    end
    chk("abort no_valid", longint'(pv), 0);
    chk("abort no_done", longint'(dn), 0);
    prev_best  = 0;
    prev_bestp = 0;
    prev_doa   = -90;

    set_data(3);
    run_scan(5, "post_rst", 1'b0, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
